// File: rtl/nova_cache_pkg.sv
// Shared types and constants for the nova_cache page cache.
// Page geometry is fixed: 4 pages of 256 bytes, tagged by the address high byte.
package nova_cache_pkg;

  localparam int PAGE_SIZE = 256;
  localparam int NUM_PAGES = 4;
  localparam int TAG_W     = 8;
  localparam int PAGE_BITS = 8;
  localparam int IDX_W     = 2;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
  } page_t;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    RESPOND
  } state_t;

  function automatic logic [IDX_W-1:0] next_victim(input logic [IDX_W-1:0] v);
    return v + IDX_W'(1);
  endfunction

endpackage

// File: rtl/nova_cache_phi2_gen.sv
// phi2 clock generator: a phase counter over PHI2_DIV fpga cycles and a registered phi2.
// While i_freeze is high both counter and phi2 hold, which stretches the high phase.
module nova_cache_phi2_gen #(
  parameter int PHI2_DIV = 16,
  parameter int CNT_W    = $clog2(PHI2_DIV)
) (
  input  logic             fpga,
  input  logic             reset,
  input  logic             i_freeze,
  output logic             o_phi2,
  output logic [CNT_W-1:0] o_cnt
);

  logic [CNT_W-1:0] r_cnt;
  logic             r_phi2;
  logic [CNT_W-1:0] w_cnt_next;

  always_comb begin
    w_cnt_next = (r_cnt == CNT_W'(PHI2_DIV - 1)) ? '0 : r_cnt + CNT_W'(1);
  end

  always_ff @(posedge fpga or posedge reset) begin
    if (reset) begin
      r_cnt  <= '0;
      r_phi2 <= 1'b0;
    end else if (!i_freeze) begin
      r_cnt  <= w_cnt_next;
      // phi2 tracks the upper half of the count so it rises at DIV/2 and falls on wrap
      r_phi2 <= (w_cnt_next >= CNT_W'(PHI2_DIV / 2));
    end
  end

  assign o_phi2 = r_phi2;
  assign o_cnt  = r_cnt;

endmodule

// File: rtl/nova_cache.sv
// Read-only fully associative page cache for a 6502 bus; also produces phi2.
// A miss freezes phi2 high while the whole 256-byte page is fetched from backing memory.
module nova_cache
  import nova_cache_pkg::*;
#(
  parameter int PHI2_DIV = 16
) (
  input  logic        fpga,
  input  logic        reset,
  input  logic [15:0] a,
  output logic [7:0]  d,
  output logic        phi2,
  output logic [15:0] mem_addr,
  output logic        mem_rd,
  input  logic [7:0]  mem_data,
  input  logic        mem_ack,
  output logic        busy
);

  localparam int CNT_W = $clog2(PHI2_DIV);

  logic [CNT_W-1:0]     w_cnt;
  logic                 w_phi2;
  logic                 w_lookup;
  logic [NUM_PAGES-1:0] w_hit_vec;
  logic                 w_hit;
  logic [IDX_W-1:0]     w_hit_idx;
  logic                 w_ram_we;

  state_t               r_state;
  page_t                r_pages [NUM_PAGES];
  logic [IDX_W-1:0]     r_victim;
  logic [IDX_W-1:0]     r_fill_idx;
  logic [IDX_W-1:0]     r_rd_page;
  logic [PAGE_BITS-1:0] r_off;
  logic [15:0]          r_addr;
  logic [7:0]           r_d;
  logic                 r_busy;
  logic                 r_mem_rd;
  logic [15:0]          r_mem_addr;

  logic [7:0]           r_ram [NUM_PAGES*PAGE_SIZE];

  nova_cache_phi2_gen #(
    .PHI2_DIV (PHI2_DIV),
    .CNT_W    (CNT_W)
  ) u_phi2_gen (
    .fpga     (fpga),
    .reset    (reset),
    .i_freeze (r_busy),
    .o_phi2   (w_phi2),
    .o_cnt    (w_cnt)
  );

  // Lookup happens once per phi2 period, one cycle after phi2 rises
  assign w_lookup = (r_state == IDLE) && !r_busy && (w_cnt == CNT_W'(PHI2_DIV / 2 + 1));

  generate
    for (genvar gi = 0; gi < NUM_PAGES; gi++) begin : g_tag_cmp
      assign w_hit_vec[gi] = r_pages[gi].valid && (r_pages[gi].tag == a[15:8]);
    end
  endgenerate

  always_comb begin
    w_hit     = |w_hit_vec;
    w_hit_idx = '0;
    for (int i = NUM_PAGES - 1; i >= 0; i--) begin
      if (w_hit_vec[i]) begin
        w_hit_idx = IDX_W'(i);
      end
    end
  end

  assign w_ram_we = (r_state == FILL) && mem_ack;

  always_ff @(posedge fpga) begin
    if (w_ram_we) begin
      r_ram[{r_fill_idx, r_off}] <= mem_data;
    end
  end

  always_ff @(posedge fpga or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      for (int i = 0; i < NUM_PAGES; i++) begin
        r_pages[i] <= '0;
      end
      r_victim   <= '0;
      r_fill_idx <= '0;
      r_rd_page  <= '0;
      r_off      <= '0;
      r_addr     <= '0;
      r_d        <= '0;
      r_busy     <= 1'b0;
      r_mem_rd   <= 1'b0;
      r_mem_addr <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_lookup) begin
            r_addr <= a;
            if (w_hit) begin
              r_rd_page <= w_hit_idx;
              r_state   <= RESPOND;
            end else begin
              // Victim is invalidated up front so an aborted fill never leaves a stale tag
              r_fill_idx              <= r_victim;
              r_pages[r_victim].valid <= 1'b0;
              r_off                   <= '0;
              r_mem_addr              <= {a[15:8], 8'h00};
              r_mem_rd                <= 1'b1;
              r_busy                  <= 1'b1;
              r_state                 <= FILL;
            end
          end
        end

        FILL: begin
          if (mem_ack) begin
            if (r_off == 8'hFF) begin
              r_pages[r_fill_idx] <= '{valid: 1'b1, tag: r_addr[15:8]};
              r_victim            <= next_victim(r_victim);
              r_rd_page           <= r_fill_idx;
              r_mem_rd            <= 1'b0;
              r_busy              <= 1'b0;
              r_state             <= RESPOND;
            end else begin
              r_off      <= r_off + 8'd1;
              r_mem_addr <= {r_addr[15:8], r_off + 8'd1};
            end
          end
        end

        RESPOND: begin
          r_d     <= r_ram[{r_rd_page, r_addr[7:0]}];
          r_state <= IDLE;
        end

        default: r_state <= IDLE;
      endcase
    end
  end

  assign d        = r_d;
  assign phi2     = w_phi2;
  assign busy     = r_busy;
  assign mem_rd   = r_mem_rd;
  assign mem_addr = r_mem_addr;

endmodule

// File: tb/tb_nova_cache.sv
// Scoreboard bench for nova_cache: expected d values are queued per access and checked at phi2 fall.
module tb_nova_cache;

  logic        fpga = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] a = 16'h0000;
  logic [7:0]  d;
  logic        phi2;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic [7:0]  mem_data;
  logic        mem_ack;
  logic        busy;
  logic        ack_en = 1'b0;

  int          checks = 0;
  int          failures = 0;
  int          reads = 0;
  int          addr_err = 0;
  logic [7:0]  exp_off = 8'h00;
  logic [7:0]  cur_pg = 8'h00;
  logic [7:0]  exp_q [$];
  logic        prev_phi2 = 1'b0;
  logic [7:0]  mon_exp;

  // Round-robin directed table: address, expected d, expected fill reads
  logic [15:0] rr_addr [13] = '{16'h1005, 16'h2005, 16'h3005, 16'h4005, 16'h5005, 16'h1005,
                                16'h3005, 16'h4005, 16'h5005, 16'h1005, 16'h2005, 16'h4005, 16'h3005};
  logic [7:0]  rr_d    [13] = '{8'h15, 8'h25, 8'h35, 8'h45, 8'h55, 8'h15,
                                8'h35, 8'h45, 8'h55, 8'h15, 8'h25, 8'h45, 8'h35};
  int          rr_rd   [13] = '{256, 256, 256, 256, 256, 256, 0, 0, 0, 0, 256, 0, 256};

  always #5 fpga = ~fpga;

  nova_cache #(.PHI2_DIV(16)) dut (
    .fpga     (fpga),
    .reset    (reset),
    .a        (a),
    .d        (d),
    .phi2     (phi2),
    .mem_addr (mem_addr),
    .mem_rd   (mem_rd),
    .mem_data (mem_data),
    .mem_ack  (mem_ack),
    .busy     (busy)
  );

  // Backing memory: acks every requested cycle, data = addr low ^ addr high
  assign mem_ack  = mem_rd & ack_en;
  assign mem_data = mem_addr[7:0] ^ mem_addr[15:8];

  always @(posedge fpga) begin
    if (reset) begin
      exp_off <= 8'h00;
    end else if (mem_rd && mem_ack) begin
      reads <= reads + 1;
      if (mem_addr !== {cur_pg, exp_off}) addr_err <= addr_err + 1;
      exp_off <= exp_off + 8'd1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge fpga) begin
    if (reset) begin
      exp_q.delete();
    end else if (prev_phi2 && !phi2 && exp_q.size() > 0) begin
      mon_exp = exp_q.pop_front();
      check("d_at_phi2_fall", {24'h0, d}, {24'h0, mon_exp});
      $display("txn a=%04h d=%02h exp=%02h", a, d, mon_exp);
    end
    prev_phi2 <= phi2;
  end

  task automatic wait_fall(input int limit, output int n);
    logic p;
    p = phi2;
    n = 0;
    while (1) begin
      @(negedge fpga);
      n++;
      if (p && !phi2) return;
      p = phi2;
      if (n >= limit) begin
        checks++;
        failures++;
        $display("FAIL phi2_fall_timeout: got no fall in %0d cycles required a fall", n);
        return;
      end
    end
  endtask

  task automatic access(input logic [15:0] addr, input logic [7:0] exp_d,
                        input int exp_reads, output int n);
    int r0;
    #2;
    a = addr;
    cur_pg = addr[15:8];
    exp_q.push_back(exp_d);
    r0 = reads;
    wait_fall(600, n);
    check("fill_reads", reads - r0, exp_reads);
  endtask

  task automatic do_reset();
    @(negedge fpga);
    reset = 1'b1;
    repeat (3) @(negedge fpga);
    check("rst_phi2", {31'h0, phi2}, 0);
    check("rst_busy", {31'h0, busy}, 0);
    check("rst_mem_rd", {31'h0, mem_rd}, 0);
    check("rst_mem_addr", {16'h0, mem_addr}, 0);
    check("rst_d", {24'h0, d}, 0);
    reset = 1'b0;
  endtask

  initial begin
    int n;
    int bad;

    // Unconnected memory: one rise, then a permanent stall with phi2 high
    a = 16'h1234;
    cur_pg = 8'h12;
    ack_en = 1'b0;
    do_reset();
    n = 0;
    while (phi2 !== 1'b1 && n < 40) begin
      @(negedge fpga);
      n++;
    end
    check("first_rise_cycles", n, 8);
    repeat (4) @(negedge fpga);
    check("stall_busy", {31'h0, busy}, 1);
    check("stall_mem_rd", {31'h0, mem_rd}, 1);
    check("stall_mem_addr", {16'h0, mem_addr}, 32'h1200);
    bad = 0;
    repeat (300) begin
      @(negedge fpga);
      if (phi2 !== 1'b1 || busy !== 1'b1) bad++;
    end
    check("stall_held_cycles_bad", bad, 0);

    // First fill, then a stream of hits within the page
    ack_en = 1'b1;
    do_reset();
    access(16'h1234, 8'h26, 256, n);
    for (int lo = 8'h34; lo <= 8'hFF; lo++) begin
      access({8'h12, 8'(lo)}, 8'(lo) ^ 8'h12, 0, n);
      check("hit_phi2_period", n, 16);
    end

    // Round-robin replacement
    do_reset();
    for (int i = 0; i < 13; i++) begin
      access(rr_addr[i], rr_d[i], rr_rd[i], n);
    end

    // Reset in the middle of a fill
    do_reset();
    #2;
    a = 16'h7710;
    cur_pg = 8'h77;
    n = 0;
    while (mem_addr !== 16'h7764 && n < 600) begin
      @(negedge fpga);
      n++;
    end
    check("midfill_reached_off100", {16'h0, mem_addr}, 32'h7764);
    reset = 1'b1;
    #1;
    check("midfill_rst_phi2", {31'h0, phi2}, 0);
    check("midfill_rst_busy", {31'h0, busy}, 0);
    check("midfill_rst_mem_rd", {31'h0, mem_rd}, 0);
    check("midfill_rst_mem_addr", {16'h0, mem_addr}, 0);
    check("midfill_rst_d", {24'h0, d}, 0);
    repeat (3) @(negedge fpga);
    reset = 1'b0;
    access(16'h7710, 8'h67, 256, n);

    // Page boundary
    access(16'h12FF, 8'hED, 256, n);
    access(16'h1300, 8'h13, 256, n);

    repeat (3) @(negedge fpga);
    check("fill_addr_sequence_errors", addr_err, 0);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/nova_cache.md
Name: nova_cache

Overview:
- Read-only, fully associative page cache sitting between the 6502 address bus and slower backing memory.
- Also generates the CPU clock phi2 by dividing the FPGA clock.
- Holds 4 pages of 256 bytes, tagged by a[15:8]. A miss stretches phi2 high while the whole page is filled.
- Returns the byte at address a on d before phi2 falls.

Parameters:
- PHI2_DIV, 16: fpga cycles per phi2 period. Must be even and >= 4. Low half = PHI2_DIV/2 cycles, high half = PHI2_DIV/2 cycles (excluding stretch).
- NUM_PAGES, 4: number of cache pages. Fixed at 4 for this revision; the victim pointer is 2 bits.
- PAGE_BITS, 8: log2 of the page size in bytes (page = 256 bytes).

Ports:
- fpga  in  1  system clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- a  in  16  CPU address.
- d  out  8  read data for a.
- phi2  out  1  CPU clock, registered.
- mem_addr  out  16  backing-memory byte address.
- mem_rd  out  1  backing-memory read request.
- mem_data  in  8  backing-memory read data, valid with mem_ack.
- mem_ack  in  1  one-cycle acknowledge; mem_data is captured on this cycle.
- busy  out  1  high while a page fill is in progress.

Behaviour:
- Reset (async, immediate) values:
  - phi2=0, d=0, busy=0, mem_rd=0, mem_addr=0.
  - Phase counter=0, victim pointer=0, all page valid bits=0, all tags=0.
  - Data RAM is not cleared.
  - Reset during a fill aborts it; the page being filled stays invalid.
- phi2 generation:
  - The counter runs 0..PHI2_DIV-1.
  - phi2 goes high when the counter reaches PHI2_DIV/2 and low when it wraps to 0.
  - The counter is frozen while busy=1.
- Lookup:
  - On the fpga edge where counter == PHI2_DIV/2+1 (one cycle after phi2 rises), sample a.
  - Compare a[15:8] against all 4 valid tags in parallel.
- Hit:
  - d updates on the next fpga edge with data[page][a[7:0]].
  - d holds until the next lookup.
  - Tags and victim pointer are unchanged.
- Miss:
  - busy=1 from the next edge; the phi2 counter freezes (phi2 stays high).
  - Victim = round-robin pointer; its valid bit is cleared.
  - Fetch sequence:
    - mem_addr = {a[15:8], offset}, offset runs 0..255.
    - mem_rd stays high until mem_ack.
    - On mem_ack, write mem_data into the victim page at offset and increment offset.
    - mem_rd and mem_addr for the next byte are presented on the following cycle.
  - After byte 255 is acked:
    - Set tag and valid; advance the victim pointer (mod 4).
    - d = data[victim][a[7:0]] on the next edge.
    - busy=0 and the counter resumes.
- Invariants:
  - d changes only while phi2 is high, so it is stable at the phi2 falling edge.
  - No two valid pages hold the same tag. This follows because fills happen only on a miss.
  - Address changes outside the lookup cycle are ignored.
  - The victim pointer wraps 3 -> 0.
- Unconnected memory (mem_ack never asserted):
  - The fill stalls indefinitely with busy=1 and phi2 held high.
  - This is a legal state, not an error.

Decomposition:
- Package nova_cache_pkg holds:
  - localparams PAGE_SIZE=256, NUM_PAGES=4, TAG_W=8.
  - A struct page_t {valid, tag[7:0]}.
  - FSM enum {IDLE, FILL, RESPOND}.
- One sub-module, nova_cache_phi2_gen: the counter plus phi2 register with a freeze input.
- Tag compare, data RAM (4x256x8) and fill FSM stay in the top.

Test Plan:
- Reset, then run with mem_ack never asserted: phi2 toggles with period 16 fpga cycles until the first lookup; then busy=1 and phi2 stays high permanently.
- Memory model acks every cycle with data = addr[7:0] ^ addr[15:8]. First access a=16'h1234 -> fill of 256 reads at 16'h1200..16'h12FF, then d=8'h26 and busy drops.
- Incrementing address 16'h1234..16'h12FF after that fill: every lookup hits, no mem_rd, phi2 period exactly 16 cycles, d matches the model.
- Access pages 10,20,30,40 then 50: the fifth miss evicts page 10 (round-robin). A later access to page 10 misses again; page 20 is evicted next.
- Assert reset mid-fill at offset 100: outputs return to reset values at once. Re-accessing the same page refills all 256 bytes from offset 0.
- Address at 16'h12FF then 16'h1300 (page boundary): the second access misses and fills page 8'h13; d correct for both.
